interrupter_seq: RTL

Supervisory sequencer that configures the interrupter from operator settings. It soft-starts pulse width, shuts down and holds off on over-current events, and latches a lockout after repeated faults. It sits between the operator setting source (pots/ADC via a valid/ready handshake) and the interrupter's freq_par/pw_par inputs. A pw_par of 0 means no output pulses.

---
 rtl/interrupter_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/interrupter_seq.sv
`default_nettype none
// ============================================================================
// Module   : interrupter_seq
// Purpose  : Supervisory sequencer for the interrupter. It soft-starts pulse
//            width, applies an over-current hold-off, and latches a lockout.
// Revision : 1.0
// ============================================================================
module interrupter_seq #(
    parameter int CLK_MHZ      = 100,
    parameter int PAR_MAX_VAL  = 255,
    parameter int RAMP_STEP_US = 1000,
    parameter int HOLD_US      = 50_000,
    parameter int FAULT_WIN_US = 1_000_000,
    parameter int FAULT_MAX    = 4,
    parameter int PW           = $clog2(PAR_MAX_VAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          ocd,
    input  logic          cfg_valid,
    input  logic [PW-1:0] cfg_freq,
    input  logic [PW-1:0] cfg_pw,
    output logic          cfg_ready,
    output logic [PW-1:0] freq_par,
    output logic [PW-1:0] pw_par,
    output logic [2:0]    state_o,
    output logic [3:0]    fault_cnt,
    output logic          lockout
);

    localparam int PRE_W  = $clog2(CLK_MHZ + 1);
    localparam int RAMP_W = $clog2(RAMP_STEP_US + 1);
    localparam int HOLD_W = $clog2(HOLD_US + 1);
    localparam int WIN_W  = $clog2(FAULT_WIN_US + 1);

    localparam logic [PRE_W-1:0]  c_pre_last  = PRE_W'(CLK_MHZ - 1);
    localparam logic [RAMP_W-1:0] c_ramp_last = RAMP_W'(RAMP_STEP_US - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_US - 1);
    localparam logic [WIN_W-1:0]  c_win_last  = WIN_W'(FAULT_WIN_US - 1);
    localparam logic [PW-1:0]     c_par_max   = PW'(PAR_MAX_VAL);
    localparam logic [3:0]        c_fault_max = 4'(FAULT_MAX);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RAMP = 3'd1,
        S_RUN  = 3'd2,
        S_HOLD = 3'd3,
        S_LOCK = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       tgt_freq_q, tgt_freq_d;
    logic [PW-1:0]       tgt_pw_q, tgt_pw_d;
    logic [PW-1:0]       freq_par_q, freq_par_d;
    logic [PW-1:0]       pw_par_q, pw_par_d;
    logic [3:0]          fault_cnt_q, fault_cnt_d;
    logic                lockout_q, lockout_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic                ocd_s1_q, ocd_s2_q, ocd_s3_q;

    logic                us_tick, ocd_rise, accept, fault, win_active, win_expire;
    logic                ramp_step, hold_done;
    logic [PW-1:0]       cfg_freq_c, cfg_pw_c, pw_inc;
    logic [3:0]          fault_base, fault_inc;

    assign us_tick    = (presc_q == c_pre_last);
    assign ocd_rise   = ocd_s2_q & ~ocd_s3_q;
    assign accept     = cfg_valid & cfg_ready_q;
    assign cfg_freq_c = (cfg_freq > c_par_max) ? c_par_max : cfg_freq;
    assign cfg_pw_c   = (cfg_pw > c_par_max) ? c_par_max : cfg_pw;
    assign pw_inc     = pw_par_q + 1'b1;
    assign ramp_step  = us_tick && (ramp_cnt_q == c_ramp_last);
    assign hold_done  = us_tick && (hold_cnt_q == c_hold_last);
    assign win_active = (state_q == S_RAMP) || (state_q == S_RUN) || (state_q == S_HOLD);
    assign win_expire = win_active && us_tick && (win_cnt_q == c_win_last);
    assign fault      = ocd_rise && ((state_q == S_RAMP) || (state_q == S_RUN));
    // A window expiring on the fault edge counts the new fault from zero.
    assign fault_base = win_expire ? 4'd0 : fault_cnt_q;
    assign fault_inc  = (fault_base == 4'hF) ? 4'hF : fault_base + 4'd1;

    always_comb begin
        state_d     = state_q;
        pw_par_d    = pw_par_q;
        fault_cnt_d = fault_base;
        presc_d     = us_tick ? '0 : presc_q + 1'b1;
        ramp_cnt_d  = ramp_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        win_cnt_d   = win_cnt_q;
        tgt_freq_d  = accept ? cfg_freq_c : tgt_freq_q;
        tgt_pw_d    = accept ? cfg_pw_c : tgt_pw_q;

        if (win_active && us_tick) begin
            win_cnt_d = win_expire ? '0 : win_cnt_q + 1'b1;
        end

        if (!en) begin
            state_d     = S_IDLE;
            pw_par_d    = '0;
            fault_cnt_d = 4'd0;
            ramp_cnt_d  = '0;
            hold_cnt_d  = '0;
            win_cnt_d   = '0;
        end else if (fault) begin
            state_d     = (fault_inc >= c_fault_max) ? S_LOCK : S_HOLD;
            pw_par_d    = '0;
            fault_cnt_d = fault_inc;
            hold_cnt_d  = '0;
            win_cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_RAMP;
                    pw_par_d   = '0;
                    ramp_cnt_d = '0;
                end
                S_RAMP: begin
                    if (pw_par_q >= tgt_pw_q) begin
                        state_d  = S_RUN;
                        pw_par_d = tgt_pw_q;
                    end else if (ramp_step) begin
                        pw_par_d   = pw_inc;
                        ramp_cnt_d = '0;
                        if (pw_inc == tgt_pw_q) begin
                            state_d = S_RUN;
                        end
                    end else if (us_tick) begin
                        ramp_cnt_d = ramp_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (cfg_pw_c <= pw_par_q) begin
                            pw_par_d = cfg_pw_c;
                        end else begin
                            state_d    = S_RAMP;
                            ramp_cnt_d = '0;
                        end
                    end
                end
                S_HOLD: begin
                    // Persistent over-current keeps re-arming the hold-off.
                    if (hold_done) begin
                        hold_cnt_d = '0;
                        if (!ocd_s2_q) begin
                            state_d    = S_RAMP;
                            pw_par_d   = '0;
                            ramp_cnt_d = '0;
                        end
                    end else if (us_tick) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        cfg_ready_d = (state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_LOCK);
        freq_par_d  = ((state_d == S_RAMP) || (state_d == S_RUN) || (state_d == S_HOLD))
                      ? tgt_freq_d : '0;
        lockout_d   = (state_d == S_LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tgt_freq_q  <= '0;
            tgt_pw_q    <= '0;
            freq_par_q  <= '0;
            pw_par_q    <= '0;
            fault_cnt_q <= 4'd0;
            lockout_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            presc_q     <= '0;
            ramp_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            win_cnt_q   <= '0;
            ocd_s1_q    <= 1'b0;
            ocd_s2_q    <= 1'b0;
            ocd_s3_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_freq_q  <= tgt_freq_d;
            tgt_pw_q    <= tgt_pw_d;
            freq_par_q  <= freq_par_d;
            pw_par_q    <= pw_par_d;
            fault_cnt_q <= fault_cnt_d;
            lockout_q   <= lockout_d;
            cfg_ready_q <= cfg_ready_d;
            presc_q     <= presc_d;
            ramp_cnt_q  <= ramp_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            win_cnt_q   <= win_cnt_d;
            ocd_s1_q    <= ocd;
            ocd_s2_q    <= ocd_s1_q;
            ocd_s3_q    <= ocd_s2_q;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign freq_par  = freq_par_q;
    assign pw_par    = pw_par_q;
    assign state_o   = state_q;
    assign fault_cnt = fault_cnt_q;
    assign lockout   = lockout_q;

endmodule
`default_nettype wire
